// File: rtl/commit_trace_fifo.sv
// Passive write-back trace tap: normalises each retiring instruction into a record,
// buffers it in a first-word-fall-through FIFO and freezes capture once the halt instruction retires.
module commit_trace_fifo #(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] HALT_INSTR = 32'hFFF00063,
    parameter int          CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [31:0]              wb_pc,
    input  logic [31:0]              wb_instr,
    input  logic [4:0]               wb_rd,
    input  logic                     wb_we,
    input  logic [31:0]              wb_wdata,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [101:0]             tr_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [101:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, next_rd;
    logic [CW-1:0] next_count;
    logic [101:0]  rec, head;
    logic          rec_we, accept, pop, full, do_write, drop;

    always_comb begin
        rec_we   = wb_we & (wb_rd != 5'd0);
        rec      = {wb_pc, wb_instr, wb_rd, rec_we, rec_we ? wb_wdata : 32'd0};
        accept   = wb_valid & ~halted;
        pop      = tr_valid & tr_ready;
        full     = (fifo_count == CW'(DEPTH));
        // When full, a same-cycle pop frees the slot the new record needs.
        do_write = accept & (~full | pop);
        drop     = accept & full & ~pop;
        next_rd  = pop ? rd_ptr + AW'(1) : rd_ptr;
        case ({do_write, pop})
            2'b10:   next_count = fifo_count + CW'(1);
            2'b01:   next_count = fifo_count - CW'(1);
            default: next_count = fifo_count;
        endcase
        // The new record becomes head directly when it lands in the slot being exposed.
        head = (do_write && next_rd == wr_ptr) ? rec : mem[next_rd];
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tr_valid   <= 1'b0;
            tr_data    <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            retire_cnt <= '0;
            halted     <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= next_rd;
            fifo_count <= next_count;
            tr_valid   <= (next_count != '0);
            tr_data    <= (next_count != '0) ? head : '0;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            if (accept) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (wb_instr == HALT_INSTR) halted <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Random and directed stimulus for commit_trace_fifo, checked against a queue-based trace model.
module tb_commit_trace_fifo;
    localparam int          DEPTH = 16;
    localparam logic [31:0] HALT  = 32'hFFF00063;

    logic         clk = 1'b0;
    logic         rst, wb_valid, wb_we, tr_ready, tr_valid, overflow, halted;
    logic [31:0]  wb_pc, wb_instr, wb_wdata, retire_cnt;
    logic [4:0]   wb_rd, fifo_count;
    logic [101:0] tr_data;
    logic [15:0]  drop_cnt;

    commit_trace_fifo #(.DEPTH(DEPTH), .HALT_INSTR(HALT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_wdata(wb_wdata), .tr_valid(tr_valid),
        .tr_ready(tr_ready), .tr_data(tr_data), .fifo_count(fifo_count), .overflow(overflow),
        .drop_cnt(drop_cnt), .retire_cnt(retire_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // reference model state
    logic [101:0] q[$];
    bit           m_over, m_halt;
    int           m_drop;
    logic [31:0]  m_ret;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [101:0] mkrec(logic [31:0] pc, logic [31:0] instr, logic [4:0] rd,
                                           logic we, logic [31:0] wd);
        logic w;
        w = we && rd != 0;
        return {pc, instr, rd, w, w ? wd : 32'd0};
    endfunction

    task automatic model_update();
        if (rst) begin
            q.delete(); m_over = 0; m_halt = 0; m_drop = 0; m_ret = 0;
        end else begin
            if (q.size() > 0 && tr_ready) void'(q.pop_front());
            if (wb_valid && !m_halt) begin
                m_ret = m_ret + 1;
                if (q.size() < DEPTH) q.push_back(mkrec(wb_pc, wb_instr, wb_rd, wb_we, wb_wdata));
                else begin
                    m_over = 1;
                    if (m_drop < 65535) m_drop++;
                end
                if (wb_instr == HALT) m_halt = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("tr_valid", tr_valid, q.size() != 0);
        chk("tr_data", tr_data, q.size() != 0 ? q[0] : 102'd0);
        chk("fifo_count", fifo_count, q.size());
        chk("overflow", overflow, m_over);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("halted", halted, m_halt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] rd, input logic we, input logic [31:0] wd, input logic rdy);
        wb_valid = v; wb_pc = pc; wb_instr = instr; wb_rd = rd; wb_we = we; wb_wdata = wd;
        tr_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int rdy_pct;
        logic [31:0] base;
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        chk("rst_valid", tr_valid, 1'b0);
        chk("rst_data", tr_data, 102'd0);
        rst = 1'b0;

        // 1: single retire, visible next cycle, popped
        drive(1, 32'h0, 32'h00A00193, 5'd3, 1, 32'hA, 1);
        cycle();
        chk("t1_valid", tr_valid, 1'b1);
        chk("t1_data", tr_data, {32'h0, 32'h00A00193, 5'd3, 1'b1, 32'hA});
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle();
        chk("t1_popped", tr_valid, 1'b0);
        chk("t1_ret", retire_cnt, 32'd1);

        // 2: non-writing and x0-writing records are normalised to no-write
        drive(1, 32'h4, 32'h00312023, 5'd5, 0, 32'h77, 0); cycle();
        drive(1, 32'h8, 32'h00500013, 5'd0, 1, 32'h5, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0); cycle();
        chk("t2_sw_wefield", tr_data[32:0], 33'd0);
        tr_ready = 1; cycle();
        chk("t2_x0_wefield", tr_data[32:0], 33'd0);
        chk("t2_x0_pc", tr_data[101:70], 32'h8);
        cycle();

        // 3: 17 retires with sink stalled -> one drop
        base = retire_cnt;
        for (int i = 0; i < 17; i++) begin
            drive(1, 32'(i * 4), 32'h00000013 + 32'(i), 5'(i), 1, 32'(i), 0);
            cycle();
        end
        chk("t3_count", fifo_count, 5'd16);
        chk("t3_over", overflow, 1'b1);
        chk("t3_drop", drop_cnt, 16'd1);
        chk("t3_ret", retire_cnt, base + 32'd17);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", tr_data[101:70], 32'(i * 4));
            cycle();
        end
        chk("t3_empty", tr_valid, 1'b0);

        // 4: full FIFO, simultaneous retire and pop -> no drop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h100 + 32'(i * 4), 32'h13, 5'd1, 1, 32'(i), 0);
            cycle();
        end
        drive(1, 32'h1000, 32'h13, 5'd2, 1, 32'hBEEF, 1);
        cycle();
        chk("t4_count", fifo_count, 5'd16);
        chk("t4_over", overflow, 1'b0);
        chk("t4_head", tr_data[101:70], 32'h104);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cycle();
        chk("t4_tail", tr_data[101:70], 32'h1000);
        cycle();

        // 5: halt freezes capture; FIFO still drains
        do_reset();
        drive(1, 32'h58, 32'h13, 5'd1, 1, 32'h1, 0); cycle();
        drive(1, 32'h5C, 32'h13, 5'd1, 1, 32'h2, 0); cycle();
        drive(1, 32'h60, HALT, 5'd0, 0, 32'h0, 0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h64 + 32'(i * 4), 32'h13, 5'd4, 1, 32'h9, 0);
            cycle();
        end
        chk("t5_halted", halted, 1'b1);
        chk("t5_ret", retire_cnt, 32'd3);
        chk("t5_count", fifo_count, 5'd3);
        drive(1, 32'h70, 32'h13, 5'd4, 1, 32'h9, 1); cycle(); cycle();
        chk("t5_last_pc", tr_data[101:70], 32'h60);
        cycle();
        chk("t5_drained", tr_valid, 1'b0);

        // 6: reset with entries queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h200 + 32'(i * 4), 32'h13, 5'd7, 1, 32'(i), 0);
            cycle();
        end
        chk("t6_pre", fifo_count, 5'd5);
        do_reset();
        chk("t6_valid", tr_valid, 1'b0);
        chk("t6_count", fifo_count, 5'd0);
        chk("t6_ret", retire_cnt, 32'd0);
        chk("t6_halt", halted, 1'b0);

        // random phase with changing sink throughput
        rdy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: rdy_pct = 0;
                    1: rdy_pct = 30;
                    2: rdy_pct = 70;
                    default: rdy_pct = 100;
                endcase
            end
            rst = ($urandom_range(0, 249) == 0);
            drive($urandom_range(0, 99) < 70, $urandom,
                  ($urandom_range(0, 599) == 0) ? HALT : $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 99) < rdy_pct);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
